rs232_tx_arbiter: RTL and testbench
===================================

Name: rs232_tx_arbiter

Overview:
- Shares one RS232 transmitter (quick_rs232 TX side, 115200 baud, 8E1) between NUM_REQ byte-stream requesters.
- Round-robin arbitration at message granularity: a granted requester keeps the line until it sends req_last or reaches MAX_BURST bytes.
- Sequences each byte through the transmitter start/busy handshake and respects peer flow control.
- Sits between the application producers (echo path, status reporter, debug) and the UART core.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_BURST, 16: maximum bytes per grant before forced re-arbitration (1..255).
- STALL_TICKS, 4340: owner-stall timeout in clk cycles, 10 bit times at 434 ticks/bit. Used only with STALL_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_data  in  NUM_REQ*8  byte per requester; requester i occupies bits [8i+7:8i].
- req_valid  in  NUM_REQ  byte valid per requester.
- req_last  in  NUM_REQ  byte is the last of a message.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_allow  in  1  peer ready to receive (RTS/CTS derived); 1 = may send.
- uart_tx_data  out  8  byte to the transmitter; held stable from start until busy falls.
- uart_tx_start  out  1  one-cycle start pulse.
- uart_tx_busy  in  1  transmitter is shifting a frame.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- active  out  1  grant held.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rr_ptr=0; burst_cnt=0. Reset mid-frame abandons the byte. The transmitter is reset by the same rst.
- IDLE:
  - If any req_valid: pick the first valid requester starting at rr_ptr and wrapping modulo NUM_REQ.
  - Set grant one-hot and active=1 on the next edge; go FETCH.
  - Selection is registered, so there is 1 cycle from valid to grant.
- FETCH:
  - When req_valid[owner] & tx_allow & !uart_tx_busy: pulse req_ready[owner] this cycle and latch data into uart_tx_data.
  - Latch last_flag = req_last[owner] | (burst_cnt == MAX_BURST-1). Increment burst_cnt. Go START.
  - If tx_allow=0, hold; no byte is accepted.
- START: uart_tx_start=1 for exactly one cycle; go WAIT_BUSY.
- WAIT_BUSY: wait for uart_tx_busy=1, then go WAIT_DONE. If busy is already 1 in the same cycle, go WAIT_DONE directly.
- WAIT_DONE: when uart_tx_busy=0:
  - If last_flag: go RELEASE.
  - Otherwise: go FETCH, keeping the grant.
- RELEASE:
  - grant=0, active=0, burst_cnt=0.
  - rr_ptr = (owner+1) mod NUM_REQ, so the released owner becomes lowest priority.
  - Go IDLE. Re-arbitration therefore takes 1 idle cycle.
- Latency: valid to first uart_tx_start is 3 cycles (IDLE→FETCH→START) when tx_allow=1 and the transmitter is idle.
- Dropping tx_allow mid-burst pauses between bytes only; a frame already started always completes.
- Valid on non-owners is ignored; their req_ready stays 0.
- Owner deasserting valid mid-message: FETCH waits indefinitely (unless STALL_TIMEOUT_EN).
- req_ready is never asserted to more than one requester, and never while uart_tx_busy=1.
- burst_cnt is 8 bits and saturates via last_flag; it never wraps.

Optional Feature:
- Macro STALL_TIMEOUT_EN.
- Defined: a 16-bit stall counter runs in FETCH while req_valid[owner]=0 and clears on any accept. On reaching STALL_TICKS, the block goes to RELEASE (rr_ptr advances past the owner) and pulses a status output stall_drop (1 bit, one cycle).
- Undefined: no counter, no stall_drop port; the owner holds the grant until last or MAX_BURST.

Decomposition:
- Shared package rs232_pkg:
  - State encoding: IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE, RELEASE.
  - RS232_BIT_TICKS = 434.
  - Byte width 8.
  - Default STALL_TICKS.
- One sub-module: rr_select, a combinational round-robin priority picker taking (valid vector, rr_ptr) and returning (one-hot, index).
- The FSM and datapath stay in the top.

Test Plan:
- Single byte: req0 sends 0x53 with last=1, tx_allow=1. Expect uart_tx_start 3 cycles after valid, uart_tx_data=0x53, req_ready[0] one pulse, grant back to 0 after busy falls, rr_ptr=1.
- Fairness: req0 and req2 both valid, each a 2-byte message (0xA1,0xA2 / 0xC1,0xC2). Expect order A1 A2 C1 C2, with no interleaving inside a message.
- MAX_BURST=4: req1 streams 6 bytes with no last while req3 is waiting. Expect 4 bytes from req1, then req3's message, then req1's remaining 2 bytes.
- Flow control: drop tx_allow after the first byte of a 3-byte message for 1000 cycles. Expect the current frame to complete, no start during the pause, then the remaining 2 bytes.
- Reset mid-frame: assert rst during WAIT_DONE. Expect grant, active, uart_tx_start and req_ready=0 immediately (async), and a normal first arbitration from requester 0 after release.
- STALL_TIMEOUT_EN defined: owner drops valid after 1 byte. Expect stall_drop pulse at STALL_TICKS and grant passed to the next valid requester.

Source files
------------

// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
//   Shared definitions for the RS232 transmit arbiter slice.
//   - state_t             : arbiter FSM state encoding
//   - BYTE_W              : width of one transmitted byte
//   - RS232_BIT_TICKS     : clk cycles per bit at 115200 baud from 50 MHz
//   - DEFAULT_STALL_TICKS : owner-stall timeout, 10 bit times
// -----------------------------------------------------------------------------
package rs232_pkg;

   localparam int BYTE_W              = 8;
   localparam int RS232_BIT_TICKS     = 434;
   localparam int DEFAULT_STALL_TICKS = 10 * RS232_BIT_TICKS;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4,
      RELEASE   = 3'd5
   } state_t;

endpackage

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
//   Combinational round-robin priority picker. Starting at ptr and wrapping
//   modulo N, returns the first set bit of valid.
//   Ports:
//     valid  in  N   request vector
//     ptr    in  IW  highest-priority position
//     onehot out N   one-hot winner (0 when no request)
//     idx    out IW  index of the winner (0 when no request)
//     any    out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_select #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   int cand;

   // Walk offsets from farthest to nearest so the position closest to ptr
   // is the last (and therefore winning) assignment.
   always_comb begin
      onehot = '0;
      idx    = '0;
      cand   = 0;
      any    = |valid;
      for (int k = N - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % N;
         if (valid[cand]) begin
            onehot = N'(1) << cand;
            idx    = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// -----------------------------------------------------------------------------
// rs232_tx_arbiter
//   Shares one RS232 transmitter between NUM_REQ byte-stream requesters with
//   message-granular round-robin arbitration. An owner keeps the line until it
//   sends req_last or has sent MAX_BURST bytes in the current grant.
//
//   Optional build macro: STALL_TIMEOUT_EN
//     When defined, an owner that leaves req_valid low in FETCH for
//     STALL_TICKS cycles loses the grant and stall_drop pulses for one cycle.
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     req_data        NUM_REQ bytes, requester i in [8i+7:8i]
//     req_valid       byte valid per requester
//     req_last        byte closes a message
//     req_ready       one-hot, one-cycle accept pulse
//     tx_allow        peer flow control, 1 = may send
//     uart_tx_data    byte to transmitter, stable from start until busy falls
//     uart_tx_start   one-cycle start pulse
//     uart_tx_busy    transmitter shifting a frame
//     grant           one-hot current owner, 0 when idle
//     active          grant held
//     stall_drop      (STALL_TIMEOUT_EN only) owner dropped for stalling
//     dbg_state       current FSM state
//
//   Handshake: a byte moves from requester i on a clock edge where
//   req_valid[i] and req_ready[i] are both 1. req_ready is only raised to the
//   owner, in FETCH, with tx_allow=1 and the transmitter idle; requesters must
//   hold data/last stable while valid is high and not yet accepted.
// -----------------------------------------------------------------------------
module rs232_tx_arbiter
   import rs232_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MAX_BURST   = 16,
   parameter int STALL_TICKS = DEFAULT_STALL_TICKS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      tx_allow,
   output logic [BYTE_W-1:0]         uart_tx_data,
   output logic                      uart_tx_start,
   input  logic                      uart_tx_busy,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      active,
`ifdef STALL_TIMEOUT_EN
   output logic                      stall_drop,
`endif
   output state_t                    dbg_state
);

   localparam int         IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t              state, state_nxt;
   logic [IW-1:0]       owner_q;
   logic [IW-1:0]       rr_ptr_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [7:0]          burst_cnt_q;
   logic                last_flag_q;
   logic [BYTE_W-1:0]   tx_data_q;

   logic [NUM_REQ-1:0]  sel_onehot;
   logic [IW-1:0]       sel_idx;
   logic                sel_any;

   logic                owner_valid;
   logic                owner_last;
   logic [BYTE_W-1:0]   owner_data;
   logic                accept;
   logic                stall_hit;

   rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
      .valid  (req_valid),
      .ptr    (rr_ptr_q),
      .onehot (sel_onehot),
      .idx    (sel_idx),
      .any    (sel_any)
   );

   assign owner_valid = req_valid[owner_q];
   assign owner_last  = req_last[owner_q];
   assign owner_data  = req_data[int'(owner_q)*BYTE_W +: BYTE_W];
   assign accept      = (state == FETCH) && owner_valid && tx_allow && !uart_tx_busy;

`ifdef STALL_TIMEOUT_EN
   logic [15:0] stall_cnt_q;

   // Counts FETCH cycles with the owner not presenting data; holds while the
   // owner is valid but blocked by flow control.
   assign stall_hit  = (state == FETCH) && !owner_valid &&
                       (stall_cnt_q == 16'(STALL_TICKS - 1));
   assign stall_drop = stall_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (state != FETCH || accept || stall_hit) begin
         stall_cnt_q <= '0;
      end else if (!owner_valid) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end
`else
   logic unused_stall_cfg;
   assign stall_hit        = 1'b0;
   assign unused_stall_cfg = (STALL_TICKS != 0);
`endif

   // Next-state and handshake outputs
   always_comb begin
      state_nxt     = state;
      req_ready     = '0;
      uart_tx_start = 1'b0;
      case (state)
         IDLE: begin
            if (sel_any) state_nxt = FETCH;
         end
         FETCH: begin
            if (accept) begin
               req_ready = NUM_REQ'(1) << owner_q;
               state_nxt = START;
            end else if (stall_hit) begin
               state_nxt = RELEASE;
            end
         end
         START: begin
            uart_tx_start = 1'b1;
            state_nxt     = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (uart_tx_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!uart_tx_busy) state_nxt = last_flag_q ? RELEASE : FETCH;
         end
         RELEASE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         last_flag_q <= 1'b0;
         tx_data_q   <= '0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && sel_any) begin
            owner_q <= sel_idx;
            grant_q <= sel_onehot;
         end

         if (accept) begin
            tx_data_q   <= owner_data;
            // Reaching the burst limit closes the grant exactly like req_last,
            // so burst_cnt never needs to wrap.
            last_flag_q <= owner_last || (burst_cnt_q == BURST_LAST);
            burst_cnt_q <= burst_cnt_q + 8'd1;
         end

         // Drop the grant on the way into RELEASE so it reads 0 there.
         if (state_nxt == RELEASE && state != RELEASE) begin
            grant_q <= '0;
         end

         if (state == RELEASE) begin
            burst_cnt_q <= '0;
            rr_ptr_q    <= IW'((int'(owner_q) + 1) % NUM_REQ);
         end
      end
   end

   assign grant        = grant_q;
   assign active       = |grant_q;
   assign uart_tx_data = tx_data_q;
   assign dbg_state    = state;

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
module tb_rs232_tx_arbiter;
  import rs232_pkg::*;

  localparam int N     = 4;
  localparam int MB    = 4;
  localparam int ST    = 200;
  localparam int FRAME = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [N*8-1:0] req_data  = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_allow  = 1'b1;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_start;
  logic           uart_tx_busy;
  logic [N-1:0]   grant;
  logic           active;
  state_t         dbg_state;
`ifdef STALL_TIMEOUT_EN
  logic           stall_drop;
`endif

  rs232_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .STALL_TICKS(ST)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_allow      (tx_allow),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .grant         (grant),
    .active        (active),
`ifdef STALL_TIMEOUT_EN
    .stall_drop    (stall_drop),
`endif
    .dbg_state     (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- transmitter model ----------------
  int tx_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_tx_busy <= 1'b0;
      tx_cnt       <= 0;
    end else if (!uart_tx_busy && uart_tx_start) begin
      uart_tx_busy <= 1'b1;
      tx_cnt       <= FRAME;
    end else if (uart_tx_busy) begin
      if (tx_cnt == 1) uart_tx_busy <= 1'b0;
      tx_cnt <= tx_cnt - 1;
    end
  end

  // ---------------- requester drivers ----------------
  logic [8:0]   src_q [N][$];   // {last, data}
  logic [N-1:0] src_hold = '0;
  logic [N-1:0] rdy_s    = '0;

  always @(negedge clk) rdy_s = req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (!rst && rdy_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0 && !src_hold[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src_q[i][0][7:0];
        req_last[i]         = src_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  end

  task automatic load(input int r, input logic [7:0] b, input logic l);
    src_q[r].push_back({l, b});
  endtask

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {requester, byte}
  logic [7:0]  held_data = '0;
  int          start_cnt = 0;

  task automatic expect_byte(input int r, input logic [7:0] b);
    exp_q.push_back({3'(r), b});
  endtask

  function automatic logic [2:0] owner_of(input logic [N-1:0] g);
    owner_of = 3'd7;
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) owner_of = 3'(i);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1 || (req_ready & ~grant) != '0 || uart_tx_busy) begin
          failures++;
          $display("FAIL ready_legal ready=%b grant=%b busy=%b", req_ready, grant, uart_tx_busy);
        end
      end
      if (uart_tx_start) begin
        logic [10:0] got;
        logic [10:0] want;
        start_cnt++;
        held_data = uart_tx_data;
        got = {owner_of(grant), uart_tx_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start got req%0d byte %h, none queued", got[10:8], got[7:0]);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL tx_byte got req%0d %h want req%0d %h", got[10:8], got[7:0], want[10:8], want[7:0]);
          end
        end
      end
      if (uart_tx_busy) begin
        checks++;
        if (uart_tx_data !== held_data) begin
          failures++;
          $display("FAIL data_stable got %h want %h", uart_tx_data, held_data);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic bit src_pending();
    src_pending = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) src_pending = 1'b1;
  endfunction

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending() || dbg_state != IDLE) && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (n < budget);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    tx_allow = 1'b1;
    src_hold = '0;
    rdy_s    = '0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks += 6;
    if (grant !== '0)        begin failures++; $display("FAIL rst_grant got %b want 0", grant); end
    if (active !== 1'b0)     begin failures++; $display("FAIL rst_active got %b want 0", active); end
    if (uart_tx_start !== 0) begin failures++; $display("FAIL rst_start got %b want 0", uart_tx_start); end
    if (req_ready !== '0)    begin failures++; $display("FAIL rst_ready got %b want 0", req_ready); end
    if (uart_tx_data !== 0)  begin failures++; $display("FAIL rst_data got %h want 0", uart_tx_data); end
    if (dbg_state !== IDLE)  begin failures++; $display("FAIL rst_state got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_single_byte();
    bit ok;
    // Valid is presented just after this edge: IDLE cycle, FETCH cycle
    // (accept), then the start pulse in the third cycle.
    @(posedge clk);
    load(0, 8'h53, 1'b1);
    expect_byte(0, 8'h53);
    @(negedge clk);
    checks++;
    if (grant !== '0) begin failures++; $display("FAIL single_grant_c1 got %b want 0000", grant); end
    @(negedge clk);
    checks += 3;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got %b want 0001", req_ready); end
    if (grant !== 4'b0001)     begin failures++; $display("FAIL single_grant got %b want 0001", grant); end
    if (active !== 1'b1)       begin failures++; $display("FAIL single_active got %b want 1", active); end
    @(negedge clk);
    checks += 2;
    if (uart_tx_start !== 1'b1) begin failures++; $display("FAIL single_start_lat got %b want 1", uart_tx_start); end
    if (uart_tx_data !== 8'h53) begin failures++; $display("FAIL single_data got %h want 53", uart_tx_data); end
    wait_drain(200, ok);
    checks += 3;
    if (!ok)               begin failures++; $display("FAIL single_drain got timeout want idle"); end
    if (grant !== '0)      begin failures++; $display("FAIL single_release got %b want 0", grant); end
    if (active !== 1'b0)   begin failures++; $display("FAIL single_inactive got %b want 0", active); end
    // rr_ptr is now 1: requester 1 must beat requester 0.
    @(posedge clk);
    load(0, 8'h10, 1'b1);
    load(1, 8'h11, 1'b1);
    expect_byte(1, 8'h11);
    expect_byte(0, 8'h10);
    wait_drain(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_ptr_drain got timeout want idle"); end
  endtask

  task automatic test_fairness();
    bit ok;
    apply_reset();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
    load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b1);
    expect_byte(0, 8'hA1); expect_byte(0, 8'hA2);
    expect_byte(2, 8'hC1); expect_byte(2, 8'hC2);
    wait_drain(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fairness_drain got timeout want idle"); end
  endtask

  task automatic test_max_burst();
    bit ok;
    apply_reset();
    for (int i = 0; i < 6; i++) load(1, 8'hB0 + 8'(i), (i == 5));
    load(3, 8'hD0, 1'b0); load(3, 8'hD1, 1'b1);
    for (int i = 0; i < 4; i++) expect_byte(1, 8'hB0 + 8'(i));
    expect_byte(3, 8'hD0); expect_byte(3, 8'hD1);
    expect_byte(1, 8'hB4); expect_byte(1, 8'hB5);
    wait_drain(800, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL burst_drain got timeout want idle"); end
  endtask

  task automatic test_flow_control();
    bit ok;
    int n;
    int starts_before;
    apply_reset();
    load(2, 8'hE0, 1'b0); load(2, 8'hE1, 1'b0); load(2, 8'hE2, 1'b1);
    expect_byte(2, 8'hE0); expect_byte(2, 8'hE1); expect_byte(2, 8'hE2);
    n = 0;
    do begin @(negedge clk); n++; end while (!uart_tx_start && n < 20);
    checks++;
    if (!uart_tx_start) begin failures++; $display("FAIL flow_first_start got none want start"); end
    @(negedge clk) tx_allow = 1'b0;
    starts_before = start_cnt;
    repeat (1000) @(negedge clk);
    checks += 4;
    if (start_cnt != starts_before) begin failures++; $display("FAIL flow_pause_starts got %0d want 0", start_cnt - starts_before); end
    if (uart_tx_busy !== 1'b0)      begin failures++; $display("FAIL flow_frame_done got busy=%b want 0", uart_tx_busy); end
    if (dbg_state !== FETCH)        begin failures++; $display("FAIL flow_hold_state got %0d want FETCH", dbg_state); end
    if (grant !== 4'b0100)          begin failures++; $display("FAIL flow_hold_grant got %b want 0100", grant); end
    tx_allow = 1'b1;
    wait_drain(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL flow_drain got timeout want idle"); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    apply_reset();
    load(3, 8'h77, 1'b1);
    expect_byte(3, 8'h77);
    n = 0;
    do begin @(negedge clk); n++; end while (dbg_state != WAIT_DONE && n < 40);
    checks++;
    if (dbg_state !== WAIT_DONE) begin failures++; $display("FAIL midrst_reach got %0d want WAIT_DONE", dbg_state); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (grant !== '0)        begin failures++; $display("FAIL midrst_grant got %b want 0", grant); end
    if (active !== 1'b0)     begin failures++; $display("FAIL midrst_active got %b want 0", active); end
    if (uart_tx_start !== 0) begin failures++; $display("FAIL midrst_start got %b want 0", uart_tx_start); end
    if (req_ready !== '0)    begin failures++; $display("FAIL midrst_ready got %b want 0", req_ready); end
    apply_reset();
    load(3, 8'h31, 1'b1);
    load(0, 8'h30, 1'b1);
    expect_byte(0, 8'h30);
    expect_byte(3, 8'h31);
    wait_drain(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_drain got timeout want idle"); end
  endtask

`ifdef STALL_TIMEOUT_EN
  task automatic test_stall_timeout();
    bit ok;
    int n;
    int fetch_n;
    apply_reset();
    load(0, 8'h40, 1'b0);
    load(1, 8'h41, 1'b1);
    expect_byte(0, 8'h40);
    expect_byte(1, 8'h41);
    n = 0;
    do begin @(negedge clk); n++; end while (!uart_tx_start && n < 20);
    fetch_n = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (dbg_state == FETCH && grant == 4'b0001) fetch_n++;
    end while (!stall_drop && n < ST + FRAME + 50);
    checks += 2;
    if (!stall_drop)   begin failures++; $display("FAIL stall_seen got none want pulse"); end
    if (fetch_n != ST) begin failures++; $display("FAIL stall_time got %0d want %0d", fetch_n, ST); end
    @(negedge clk);
    checks++;
    if (stall_drop !== 1'b0) begin failures++; $display("FAIL stall_pulse_width got %b want 0", stall_drop); end
    wait_drain(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_drain got timeout want idle"); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk) rst = 1'b0;
    test_single_byte();
    test_fairness();
    test_max_burst();
    test_flow_control();
    test_reset_mid_frame();
`ifdef STALL_TIMEOUT_EN
    test_stall_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
